// File: rtl/ci_initiator_if.sv
// ci_initiator_if: request, response and OR-combined CI bus signals of the CI initiator.
interface ci_initiator_if;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_n;
  logic [31:0] req_data_a;
  logic [31:0] req_data_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_timeout;
  logic [7:0]  ci_n;
  logic [31:0] ci_data_a;
  logic [31:0] ci_data_b;
  logic        ci_start;
  logic        ci_cke;
  logic        ci_done;
  logic [31:0] ci_result;
  modport master (
    input  req_valid, req_n, req_data_a, req_data_b, rsp_ready, ci_done, ci_result,
    output req_ready, rsp_valid, rsp_result, rsp_timeout, ci_n, ci_data_a, ci_data_b, ci_start, ci_cke
  );
  modport slave (
    output req_valid, req_n, req_data_a, req_data_b, rsp_ready, ci_done, ci_result,
    input  req_ready, rsp_valid, rsp_result, rsp_timeout, ci_n, ci_data_a, ci_data_b, ci_start, ci_cke
  );
endinterface

// File: rtl/ci_initiator.sv
// ci_initiator: issues one custom instruction at a time on the OR-combined CI bus and returns its result.
module ci_initiator #(
  parameter logic [15:0] timeout_cycles = 16'd255
) (
  input logic            clk,
  input logic            rst_n,
  ci_initiator_if.master bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t      state, state_d;
  logic [7:0]  n_q, n_d;
  logic [31:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic        to_q, to_d;
  logic [15:0] cnt_q, cnt_d;
  logic        live;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      n_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      to_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      state <= state_d;
      n_q   <= n_d;
      a_q   <= a_d;
      b_q   <= b_d;
      res_q <= res_d;
      to_q  <= to_d;
      cnt_q <= cnt_d;
    end
  end
  // done in the same cycle as the timeout limit takes priority as a normal completion
  always_comb begin
    state_d = state;
    n_d     = n_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    to_d    = to_q;
    cnt_d   = cnt_q;
    case (state)
      IDLE:
        if (bus.req_valid) begin
          n_d     = bus.req_n;
          a_d     = bus.req_data_a;
          b_d     = bus.req_data_b;
          state_d = ISSUE;
        end
      ISSUE: begin
        cnt_d   = '0;
        state_d = bus.ci_done ? RESP : WAIT;
        res_d   = bus.ci_done ? bus.ci_result : res_q;
        to_d    = bus.ci_done ? 1'b0 : to_q;
      end
      WAIT:
        if (bus.ci_done) begin
          res_d   = bus.ci_result;
          to_d    = 1'b0;
          state_d = RESP;
        end else if (cnt_q == timeout_cycles - 16'd1) begin
          res_d   = '0;
          to_d    = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      default:
        state_d = bus.rsp_ready ? IDLE : RESP;
    endcase
  end
  assign live            = (state == ISSUE) || (state == WAIT);
  assign bus.req_ready   = state == IDLE;
  assign bus.rsp_valid   = state == RESP;
  assign bus.rsp_result  = res_q;
  assign bus.rsp_timeout = to_q;
  assign bus.ci_start    = state == ISSUE;
  assign bus.ci_cke      = live;
  assign bus.ci_n        = live ? n_q : '0;
  assign bus.ci_data_a   = live ? a_q : '0;
  assign bus.ci_data_b   = live ? b_q : '0;
endmodule
